// File: rtl/dec_share_arbiter_pkg.sv
// Shared definitions for the decrement-sharing arbiter: default sizes
// and the width of the requester index carried with each result.
package dec_share_arbiter_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 16;

   // Index width for n requesters; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dec_share_arbiter_rr_pick.sv
// Round-robin picker: finds the first requesting index above the last
// winner (wrapping), and returns it as a one-hot grant plus an index.
module dec_share_arbiter_rr_pick
   import dec_share_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDW   = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDW-1:0]   i_rr_ptr,
   input  logic             i_en_free,
   output logic [N_REQ-1:0] o_grant,
   output logic [IDW-1:0]   o_idx,
   output logic             o_any
);

   // Search upward from rr_ptr+1; the first hit wins, nothing wins when blocked.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (i_en_free && !o_any && i_req[(int'(i_rr_ptr) + k) % N_REQ]) begin
            o_any   = 1'b1;
            o_grant[(int'(i_rr_ptr) + k) % N_REQ] = 1'b1;
            o_idx   = IDW'((int'(i_rr_ptr) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/dec_share_arbiter.sv
// Shared decrementer: N requesters compete round-robin for a single
// registered result slot holding operand-1 plus zero/wrap flags.
module dec_share_arbiter
   import dec_share_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   localparam int IDW  = id_width(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] operand,
   output logic [N_REQ-1:0]       grant,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_zero,
   output logic                   rsp_wrap
);

   logic             r_valid;
   logic [IDW-1:0]   r_id;
   logic [WIDTH-1:0] r_data;
   logic             r_zero;
   logic             r_wrap;
   logic [IDW-1:0]   r_ptr;

   logic             w_slot_free;
   logic             w_en_free;
   logic [N_REQ-1:0] w_grant;
   logic [IDW-1:0]   w_idx;
   logic             w_any;
   logic [WIDTH-1:0] w_opnd [N_REQ];
   logic [WIDTH-1:0] w_sel;
   logic [WIDTH-1:0] w_dec;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_opnd
      assign w_opnd[gi] = operand[gi*WIDTH +: WIDTH];
   end

   // The slot can take a new result when empty or being drained this edge;
   // grants are also suppressed while reset is held.
   assign w_slot_free = !r_valid || rsp_ready;
   assign w_en_free   = en && w_slot_free && rst_n;

   dec_share_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_rr_pick (
      .i_req     (req),
      .i_rr_ptr  (r_ptr),
      .i_en_free (w_en_free),
      .o_grant   (w_grant),
      .o_idx     (w_idx),
      .o_any     (w_any)
   );

   assign w_sel = w_opnd[w_idx];
   assign w_dec = w_sel - WIDTH'(1);

   // Result slot and round-robin pointer; a grant overwrites the slot even
   // on a handshake edge, otherwise a handshake empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_id    <= '0;
         r_data  <= '0;
         r_zero  <= 1'b0;
         r_wrap  <= 1'b0;
         r_ptr   <= IDW'(N_REQ - 1);
      end else if (w_any) begin
         r_valid <= 1'b1;
         r_id    <= w_idx;
         r_data  <= w_dec;
         r_zero  <= (w_dec == '0);
         r_wrap  <= (w_sel == '0);
         r_ptr   <= w_idx;
      end else if (r_valid && rsp_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign grant     = w_grant;
   assign rsp_valid = r_valid;
   assign rsp_id    = r_id;
   assign rsp_data  = r_data;
   assign rsp_zero  = r_zero;
   assign rsp_wrap  = r_wrap;

endmodule

// File: tb/tb_dec_share_arbiter.sv
// Bench for dec_share_arbiter: directed vector table, reset corner cases,
// then randomized traffic against a behavioural model with fairness checks.
module tb_dec_share_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [N-1:0] req;
   logic [N*W-1:0] operand;
   logic [N-1:0] grant;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_id;
   logic [W-1:0] rsp_data;
   logic         rsp_zero;
   logic         rsp_wrap;

   int n_cmp  = 0;
   int n_fail = 0;

   // behavioural model state
   int           m_ptr;
   bit           m_valid;
   int           m_id;
   logic [W-1:0] m_data;
   bit           m_zero;
   bit           m_wrap;
   int           wait_cnt [N];

   typedef struct {
      logic         en;
      logic [N-1:0] req;
      logic         rdy;
      logic [W-1:0] op2;
      logic [N-1:0] g;
      logic         v;
      logic [1:0]   id;
      logic [W-1:0] d;
      logic         z;
      logic         w;
   } vec_t;

   vec_t tv [18];

   always #5 clk = ~clk;

   dec_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .operand   (operand),
      .grant     (grant),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_zero  (rsp_zero),
      .rsp_wrap  (rsp_wrap)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = N - 1; m_valid = 0; m_id = 0; m_data = '0; m_zero = 0; m_wrap = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
   endtask

   // Winner = requesting index with the smallest forward distance from the last winner.
   function automatic int model_pick();
      int best  = -1;
      int bestd = N + 1;
      if (!rst_n || !en || (m_valid && !rsp_ready)) return -1;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            int d = (i - m_ptr - 1 + 2 * N) % N;
            if (d < bestd) begin bestd = d; best = i; end
         end
      end
      return best;
   endfunction

   function automatic logic [N-1:0] onehot(input int g);
      logic [N-1:0] r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic model_edge(input int g);
      if (g >= 0) begin
         logic [W-1:0] op = operand[g*W +: W];
         m_valid = 1; m_id = g; m_data = op - 16'd1;
         m_zero = (m_data == 0); m_wrap = (op == 0); m_ptr = g;
      end else if (m_valid && rsp_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic chk_model_outputs();
      chk("valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
         chk("id",   32'(rsp_id),   32'(m_id));
         chk("data", 32'(rsp_data), 32'(m_data));
         chk("zero", 32'(rsp_zero), 32'(m_zero));
         chk("wrap", 32'(rsp_wrap), 32'(m_wrap));
      end
   endtask

   // Apply one table row from a negedge; check grant before the edge and outputs after.
   task automatic run_vec(input int n, input vec_t v);
      int g;
      en = v.en; req = v.req; rsp_ready = v.rdy; operand[2*W +: W] = v.op2;
      #1;
      g = model_pick();
      chk($sformatf("v%0d_grant", n), 32'(grant), 32'(v.g));
      @(posedge clk);
      model_edge(g);
      #1;
      chk($sformatf("v%0d_valid", n), 32'(rsp_valid), 32'(v.v));
      chk($sformatf("v%0d_id", n),    32'(rsp_id),    32'(v.id));
      chk($sformatf("v%0d_data", n),  32'(rsp_data),  32'(v.d));
      chk($sformatf("v%0d_zero", n),  32'(rsp_zero),  32'(v.z));
      chk($sformatf("v%0d_wrap", n),  32'(rsp_wrap),  32'(v.w));
      $display("vec %0d: en=%b req=%b rdy=%b grant=%b -> valid=%b id=%0d data=%h z=%b w=%b",
               n, v.en, v.req, v.rdy, grant, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_wrap);
      @(negedge clk);
   endtask

   // One randomized cycle from a negedge, checked against the model.
   task automatic run_random(input int n);
      int g;
      en = ($urandom_range(9) != 0);
      rsp_ready = ($urandom_range(9) < 7);
      for (int i = 0; i < N; i++) begin
         if (!req[i] && $urandom_range(2) == 0) begin
            req[i] = 1'b1;
            operand[i*W +: W] = ($urandom_range(3) == 0) ? W'($urandom_range(1)) : W'($urandom);
         end
      end
      #1;
      g = model_pick();
      chk("rnd_grant", 32'(grant), 32'(onehot(g)));
      if (g >= 0) begin
         for (int i = 0; i < N; i++) begin
            if (i != g && req[i]) begin
               wait_cnt[i]++;
               chk("fair_wait_ok", 32'(wait_cnt[i] <= N - 1), 32'd1);
            end
         end
         wait_cnt[g] = 0;
      end
      @(posedge clk);
      model_edge(g);
      #1;
      chk_model_outputs();
      if (g >= 0)
         $display("rnd %0d: grant %0d op=%h -> data=%h z=%b w=%b", n, g,
                  operand[g*W +: W], rsp_data, rsp_zero, rsp_wrap);
      @(negedge clk);
      if (g >= 0) req[g] = 1'b0;
   endtask

   initial begin
      // fixed operands: requester i holds 16'h0100 + i (requester 2 set per row)
      tv[0]  = '{1'b1, 4'b1111, 1'b1, 16'h0102, 4'b0001, 1'b1, 2'd0, 16'h00FF, 1'b0, 1'b0};
      tv[1]  = '{1'b1, 4'b1111, 1'b1, 16'h0102, 4'b0010, 1'b1, 2'd1, 16'h0100, 1'b0, 1'b0};
      tv[2]  = '{1'b1, 4'b1111, 1'b1, 16'h0102, 4'b0100, 1'b1, 2'd2, 16'h0101, 1'b0, 1'b0};
      tv[3]  = '{1'b1, 4'b1111, 1'b1, 16'h0102, 4'b1000, 1'b1, 2'd3, 16'h0102, 1'b0, 1'b0};
      tv[4]  = '{1'b1, 4'b1111, 1'b1, 16'h0102, 4'b0001, 1'b1, 2'd0, 16'h00FF, 1'b0, 1'b0};
      // operand wrap / reach zero
      tv[5]  = '{1'b1, 4'b0100, 1'b1, 16'h0000, 4'b0100, 1'b1, 2'd2, 16'hFFFF, 1'b0, 1'b1};
      tv[6]  = '{1'b1, 4'b0100, 1'b1, 16'h0001, 4'b0100, 1'b1, 2'd2, 16'h0000, 1'b1, 1'b0};
      // enable low: result drains, nothing new; then enable high grants immediately
      tv[7]  = '{1'b0, 4'b1000, 1'b1, 16'h0001, 4'b0000, 1'b0, 2'd2, 16'h0000, 1'b1, 1'b0};
      tv[8]  = '{1'b1, 4'b1000, 1'b1, 16'h0001, 4'b1000, 1'b1, 2'd3, 16'h0102, 1'b0, 1'b0};
      // backpressure three cycles, then resume in the same cycle ready rises
      tv[9]  = '{1'b1, 4'b0011, 1'b0, 16'h0001, 4'b0000, 1'b1, 2'd3, 16'h0102, 1'b0, 1'b0};
      tv[10] = '{1'b1, 4'b0011, 1'b0, 16'h0001, 4'b0000, 1'b1, 2'd3, 16'h0102, 1'b0, 1'b0};
      tv[11] = '{1'b1, 4'b0011, 1'b0, 16'h0001, 4'b0000, 1'b1, 2'd3, 16'h0102, 1'b0, 1'b0};
      tv[12] = '{1'b1, 4'b0011, 1'b1, 16'h0001, 4'b0001, 1'b1, 2'd0, 16'h00FF, 1'b0, 1'b0};
      tv[13] = '{1'b1, 4'b0011, 1'b1, 16'h0001, 4'b0010, 1'b1, 2'd1, 16'h0100, 1'b0, 1'b0};
      // requester 1 held, requester 3 re-raised every cycle: they alternate
      tv[14] = '{1'b1, 4'b1010, 1'b1, 16'h0001, 4'b1000, 1'b1, 2'd3, 16'h0102, 1'b0, 1'b0};
      tv[15] = '{1'b1, 4'b1010, 1'b1, 16'h0001, 4'b0010, 1'b1, 2'd1, 16'h0100, 1'b0, 1'b0};
      tv[16] = '{1'b1, 4'b1010, 1'b1, 16'h0001, 4'b1000, 1'b1, 2'd3, 16'h0102, 1'b0, 1'b0};
      tv[17] = '{1'b1, 4'b1010, 1'b1, 16'h0001, 4'b0010, 1'b1, 2'd1, 16'h0100, 1'b0, 1'b0};

      operand = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
      rst_n = 1'b0; en = 1'b1; req = 4'b1111; rsp_ready = 1'b1;
      model_reset();
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_id",    32'(rsp_id),    32'd0);
      chk("rst_data",  32'(rsp_data),  32'd0);
      chk("rst_zero",  32'(rsp_zero),  32'd0);
      chk("rst_wrap",  32'(rsp_wrap),  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) run_vec(i, tv[i]);

      // reset while a result is stalled: valid must drop with no clock edge
      rsp_ready = 1'b0; req = 4'b0001; en = 1'b1;
      #1;
      chk("mid_valid_before", 32'(rsp_valid), 32'd1);
      chk("mid_grant_stall",  32'(grant),     32'd0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_valid_async", 32'(rsp_valid), 32'd0);
      chk("mid_grant_rst",   32'(grant),     32'd0);
      $display("mid-reset: valid=%b grant=%b", rsp_valid, grant);
      @(negedge clk);
      rst_n = 1'b1; req = 4'b1111; rsp_ready = 1'b1;
      #1;
      chk("post_rst_grant", 32'(grant), 32'b0001);
      @(posedge clk);
      model_edge(0);
      #1;
      chk("post_rst_id",    32'(rsp_id),   32'd0);
      chk("post_rst_data",  32'(rsp_data), 32'h00FF);
      $display("post-reset: grant0 -> id=%0d data=%h", rsp_id, rsp_data);
      @(negedge clk);

      req = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int n = 0; n < 400; n++) run_random(n);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
